// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
// Module   : text_console
// Brief    : Byte-stream terminal front end for the character VRAM. Accepts
//            bytes over valid/ready, tracks a cursor on a COLS x ROWS grid
//            and issues single-cycle cell writes. Handles printable bytes,
//            CR, LF, BS, TAB and FF (clear screen); clears the screen after
//            reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   pixel clock (VRAM domain)
//   reset_n     in   asynchronous active-low reset
//   in_valid    in   in_char holds a byte
//   in_ready    out  byte accepted on this edge when in_valid is also high
//   in_char     in   byte to interpret
//   write_ce    out  VRAM write strobe, one cycle per cell
//   write_row   out  VRAM row    (held while write_ce = 0)
//   write_col   out  VRAM column (held while write_ce = 0)
//   write_data  out  VRAM byte   (held while write_ce = 0)
//   cursor_row  out  current cursor row
//   cursor_col  out  current cursor column
// ============================================================================
module text_console #(
  parameter int         COLS  = 100,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20,
  parameter int         TAB_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  output logic       write_ce,
  output logic [4:0] write_row,
  output logic [6:0] write_col,
  output logic [7:0] write_data,
  output logic [4:0] cursor_row,
  output logic [6:0] cursor_col
);

  localparam logic [4:0] C_ROW_LAST = 5'(ROWS - 1);
  localparam logic [6:0] C_COL_LAST = 7'(COLS - 1);
  localparam logic [7:0] C_COLS8    = 8'(COLS);
  localparam logic [7:0] C_TAB_MASK = 8'(TAB_W - 1);

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_HT = 8'h09;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_FF = 8'h0C;
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_DEL = 8'h7F;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t     r_state,     w_state_nxt;
  logic [4:0] r_clr_row,   w_clr_row_nxt;
  logic [6:0] r_clr_col,   w_clr_col_nxt;
  logic [4:0] r_cur_row,   w_cur_row_nxt;
  logic [6:0] r_cur_col,   w_cur_col_nxt;
  logic       r_we,        w_we_nxt;
  logic [4:0] r_wrow,      w_wrow_nxt;
  logic [6:0] r_wcol,      w_wcol_nxt;
  logic [7:0] r_wdata,     w_wdata_nxt;

  logic [7:0] w_tab_col;
  logic       w_printable;

  // Row increment with wrap; there is no scrolling.
  function automatic logic [4:0] row_inc(input logic [4:0] r);
    return (r == C_ROW_LAST) ? 5'd0 : r + 5'd1;
  endfunction

  // Next tab stop, computed in 8 bits so the compare against COLS cannot
  // be fooled by a 7-bit wrap.
  assign w_tab_col   = ({1'b0, r_cur_col} | C_TAB_MASK) + 8'd1;
  assign w_printable = (in_char >= 8'h20) && (in_char != C_DEL);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_CLEAR;
      r_clr_row <= 5'd0;
      r_clr_col <= 7'd0;
      r_cur_row <= 5'd0;
      r_cur_col <= 7'd0;
      r_we      <= 1'b0;
      r_wrow    <= 5'd0;
      r_wcol    <= 7'd0;
      r_wdata   <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_row <= w_clr_row_nxt;
      r_clr_col <= w_clr_col_nxt;
      r_cur_row <= w_cur_row_nxt;
      r_cur_col <= w_cur_col_nxt;
      r_we      <= w_we_nxt;
      r_wrow    <= w_wrow_nxt;
      r_wcol    <= w_wcol_nxt;
      r_wdata   <= w_wdata_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_row_nxt = r_clr_row;
    w_clr_col_nxt = r_clr_col;
    w_cur_row_nxt = r_cur_row;
    w_cur_col_nxt = r_cur_col;
    w_we_nxt      = 1'b0;
    w_wrow_nxt    = r_wrow;
    w_wcol_nxt    = r_wcol;
    w_wdata_nxt   = r_wdata;

    case (r_state)
      ST_CLEAR: begin
        // Present the current counter cell, then step row-major.
        w_we_nxt    = 1'b1;
        w_wrow_nxt  = r_clr_row;
        w_wcol_nxt  = r_clr_col;
        w_wdata_nxt = BLANK;
        if (r_clr_col == C_COL_LAST) begin
          w_clr_col_nxt = 7'd0;
          if (r_clr_row == C_ROW_LAST) begin
            w_clr_row_nxt = 5'd0;
            w_state_nxt   = ST_IDLE;
            w_cur_row_nxt = 5'd0;
            w_cur_col_nxt = 7'd0;
          end else begin
            w_clr_row_nxt = r_clr_row + 5'd1;
          end
        end else begin
          w_clr_col_nxt = r_clr_col + 7'd1;
        end
      end

      ST_IDLE: begin
        if (in_valid) begin
          case (in_char)
            C_CR: w_cur_col_nxt = 7'd0;
            C_LF: w_cur_row_nxt = row_inc(r_cur_row);
            C_BS: begin
              if (r_cur_col != 7'd0) begin
                w_cur_col_nxt = r_cur_col - 7'd1;
              end else if (r_cur_row != 5'd0) begin
                w_cur_row_nxt = r_cur_row - 5'd1;
                w_cur_col_nxt = C_COL_LAST;
              end
            end
            C_HT: begin
              if (w_tab_col < C_COLS8) begin
                w_cur_col_nxt = w_tab_col[6:0];
              end else begin
                w_cur_row_nxt = row_inc(r_cur_row);
                w_cur_col_nxt = 7'd0;
              end
            end
            C_FF: begin
              // Cursor is left alone; the clear homes it on its last cell.
              w_state_nxt   = ST_CLEAR;
              w_clr_row_nxt = 5'd0;
              w_clr_col_nxt = 7'd0;
            end
            default: begin
              if (w_printable) begin
                w_we_nxt    = 1'b1;
                w_wrow_nxt  = r_cur_row;
                w_wcol_nxt  = r_cur_col;
                w_wdata_nxt = in_char;
                if (r_cur_col == C_COL_LAST) begin
                  w_cur_col_nxt = 7'd0;
                  w_cur_row_nxt = row_inc(r_cur_row);
                end else begin
                  w_cur_col_nxt = r_cur_col + 7'd1;
                end
              end
            end
          endcase
        end
      end

      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign write_ce   = r_we;
  assign write_row  = r_wrow;
  assign write_col  = r_wcol;
  assign write_data = r_wdata;
  assign cursor_row = r_cur_row;
  assign cursor_col = r_cur_col;

endmodule
`default_nettype wire

// File: tb/tb_text_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_console
// Brief    : Directed self-checking bench for text_console.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_console;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       write_ce;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_data;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;

  int checks = 0;
  int errors = 0;

  text_console dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .write_ce   (write_ce),
    .write_row  (write_row),
    .write_col  (write_col),
    .write_data (write_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cur(input string tag, input logic [4:0] r, input logic [6:0] c);
    checks++;
    assert ({cursor_row, cursor_col} === {r, c}) else begin
      errors++;
      $error("FAIL %s cursor observed=(%0d,%0d) expected=(%0d,%0d)",
             tag, cursor_row, cursor_col, r, c);
    end
  endtask

  task automatic chk_nowr(input string tag);
    checks++;
    assert (write_ce === 1'b0) else begin
      errors++;
      $error("FAIL %s write_ce observed=%b expected=0", tag, write_ce);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] r, input logic [6:0] c,
                        input logic [7:0] d);
    checks++;
    assert ({write_ce, write_row, write_col, write_data} === {1'b1, r, c, d}) else begin
      errors++;
      $error("FAIL %s write observed=ce%b (%0d,%0d)=%h expected=ce1 (%0d,%0d)=%h",
             tag, write_ce, write_row, write_col, write_data, r, c, d);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_char  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic sendn(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  // Runs 3000 clock edges of a screen clear, checking every cell in
  // row-major order, in_ready low until the last edge and the cursor held
  // at (cr,cc) until the clear homes it.
  task automatic run_clear(input string tag, input logic [4:0] cr, input logic [6:0] cc);
    int seq_bad = 0;
    int rdy_bad = 0;
    int cur_bad = 0;
    int pulses  = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (write_ce === 1'b1) pulses++;
      if (!(write_ce === 1'b1 && write_row === 5'(i / 100) &&
            write_col === 7'(i % 100) && write_data === 8'h20)) seq_bad++;
      if (in_ready !== (i == 2999)) rdy_bad++;
      if (i < 2999) begin
        if ({cursor_row, cursor_col} !== {cr, cc}) cur_bad++;
      end else begin
        if ({cursor_row, cursor_col} !== 12'd0) cur_bad++;
      end
    end
    chk({tag, "_pulses"}, pulses, 32'd3000);
    chk({tag, "_cell_seq_bad"}, seq_bad, 32'd0);
    chk({tag, "_ready_bad"}, rdy_bad, 32'd0);
    chk({tag, "_cursor_bad"}, cur_bad, 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;

    // Reset values
    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_outs", {9'd0, write_ce, write_row, write_col, write_data}, 32'd0);
    chk_cur("rst_cursor", 5'd0, 7'd0);

    // Reset release and the automatic clear
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_clear("clr_reset", 5'd0, 7'd0);

    // "AB" back to back
    send(8'h41);
    chk_wr("ab_A", 5'd0, 7'd0, 8'h41);
    chk_cur("ab_A_cur", 5'd0, 7'd1);
    chk("ab_A_ready", {31'd0, in_ready}, 32'd1);
    send(8'h42);
    chk_wr("ab_B", 5'd0, 7'd1, 8'h42);
    chk_cur("ab_B_cur", 5'd0, 7'd2);
    chk("ab_B_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_nowr("ab_idle_ce");
    chk("ab_idle_hold", {24'd0, write_data}, 32'h42);

    // Line wrap at (0,99)
    sendn(8'h09, 12);              // (0,2) -> (0,96)
    chk_cur("tab_chain", 5'd0, 7'd96);
    sendn(8'h78, 3);               // -> (0,99)
    send(8'h5A);
    chk_wr("wrap_0_99", 5'd0, 7'd99, 8'h5A);
    chk_cur("wrap_0_99_cur", 5'd1, 7'd0);

    // Wrap from (29,99) to (0,0)
    sendn(8'h0A, 28);              // -> (29,0)
    sendn(8'h09, 12);              // -> (29,96)
    sendn(8'h78, 3);               // -> (29,99)
    chk_cur("at_29_99", 5'd29, 7'd99);
    send(8'h5A);
    chk_wr("wrap_29_99", 5'd29, 7'd99, 8'h5A);
    chk_cur("wrap_29_99_cur", 5'd0, 7'd0);

    // BS at home does nothing
    send(8'h08);
    chk_cur("bs_home", 5'd0, 7'd0);
    chk_nowr("bs_home_ce");

    // LF wrap from (29,5)
    sendn(8'h0A, 29);
    sendn(8'h78, 5);
    chk_cur("at_29_5", 5'd29, 7'd5);
    send(8'h0A);
    chk_cur("lf_wrap", 5'd0, 7'd5);
    chk_nowr("lf_wrap_ce");

    // CR and TAB at (3,10)
    sendn(8'h0A, 3);
    sendn(8'h78, 5);
    chk_cur("at_3_10", 5'd3, 7'd10);
    send(8'h0D);
    chk_cur("cr", 5'd3, 7'd0);
    chk_nowr("cr_ce");
    sendn(8'h78, 10);
    send(8'h09);
    chk_cur("tab_3_10", 5'd3, 7'd16);
    chk_nowr("tab_ce");

    // TAB past the last stop wraps the row
    sendn(8'h09, 10);              // -> (3,96)
    send(8'h78);                   // -> (3,97)
    send(8'h09);
    chk_cur("tab_3_97", 5'd4, 7'd0);

    // BS at column 0 goes to previous row end
    send(8'h08);
    chk_cur("bs_4_0", 5'd3, 7'd99);

    // Ignored bytes
    send(8'h00);
    chk_cur("nul_cur", 5'd3, 7'd99);
    chk_nowr("nul_ce");
    send(8'h7F);
    chk_cur("del_cur", 5'd3, 7'd99);
    chk_nowr("del_ce");

    // Form-feed at (7,42) with a byte queued behind it
    sendn(8'h0A, 4);
    send(8'h0D);
    sendn(8'h09, 5);
    sendn(8'h78, 2);
    chk_cur("at_7_42", 5'd7, 7'd42);
    in_valid = 1'b1;
    in_char  = 8'h0C;
    tick();
    chk("ff_ready", {31'd0, in_ready}, 32'd0);
    chk_nowr("ff_ce");
    chk_cur("ff_cur", 5'd7, 7'd42);
    in_char = 8'h41;               // held valid across the whole clear
    run_clear("clr_ff", 5'd7, 7'd42);
    tick();
    chk_wr("after_ff_A", 5'd0, 7'd0, 8'h41);
    chk_cur("after_ff_cur", 5'd0, 7'd1);
    in_valid = 1'b0;
    tick();
    chk_nowr("after_ff_idle");

    // Reset in the middle of a clear
    send(8'h0C);
    for (int i = 0; i < 1500; i++) tick();
    chk_wr("mid_clear_1500", 5'd14, 7'd99, 8'h20);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_outs", {9'd0, write_ce, write_row, write_col, write_data}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd0);
    chk_cur("midrst_cur", 5'd0, 7'd0);
    tick();
    tick();
    reset_n = 1'b1;
    run_clear("clr_rerun", 5'd0, 7'd0);
    tick();
    chk_nowr("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
